// File: rtl/sub_bytes_seq.sv
// Sequential AES SubBytes engine: LANES S-box lanes sweep the 16-byte state over 16/LANES cycles.
// Forward and inverse substitution share one GF(2^8) inverter per lane.

module sub_bytes_lane #(
    parameter int INV_EN = 1
) (
    input  logic [7:0] b,
    input  logic       inv,
    output logic [7:0] s
);
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, bb, p;
        a  = a_in;
        bb = b_in;
        p  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ a;
            a  = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES requires
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r, p;
        logic [7:0] e;
        r = 8'h01;
        p = x;
        e = 8'hfe;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, p);
            p = gmul(p, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    logic       use_inv;
    logic [7:0] pre, y, fwd;

    assign use_inv = (INV_EN != 0) && inv;
    assign pre     = use_inv ? (rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05) : b;
    assign y       = ginv(pre);
    assign fwd     = y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
    assign s       = use_inv ? y : fwd;
endmodule

module sub_bytes_seq #(
    parameter int LANES  = 4,
    parameter int INV_EN = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SUB  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // STEP truncates to 0 for LANES=16, which is exactly the wrap we want
    localparam logic [3:0] STEP = 4'(LANES);
    localparam logic [3:0] LAST = 4'(16 - LANES);

    logic [1:0]              state;
    logic [3:0]              idx;
    logic                    mode;
    logic [0:15][7:0]        work, work_nxt;
    logic [LANES-1:0][7:0]   lane_in, lane_out;

    always_comb begin
        lane_in = '0;
        for (int l = 0; l < LANES; l++) lane_in[l] = work[idx + 4'(l)];
    end

    sub_bytes_lane #(.INV_EN(INV_EN)) u_lane [LANES-1:0] (
        .b   (lane_in),
        .inv (mode),
        .s   (lane_out)
    );

    always_comb begin
        work_nxt = work;
        for (int l = 0; l < LANES; l++) work_nxt[idx + 4'(l)] = lane_out[l];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            mode  <= 1'b0;
            work  <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    work  <= in_data;
                    mode  <= in_inv & (INV_EN != 0);
                    idx   <= '0;
                    state <= SUB;
                end
                SUB: begin
                    work <= work_nxt;
                    idx  <= idx + STEP;
                    if (idx == LAST) state <= DONE;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign out_data  = work;
    assign busy      = (state == SUB) || (state == DONE);
endmodule

// File: tb/tb_sub_bytes_seq.sv
// Scoreboard bench for sub_bytes_seq: four configurations (L4/inv, L1, L16, L4 forward-only).
// Drivers push expected blocks into a queue; a negedge monitor pops and compares on handshake.

module tb_sub_bytes_seq;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   in_valid = '0;
    logic [3:0]   in_ready, out_valid, busy;
    logic [3:0]   out_ready = '0;
    logic [127:0] in_data = '0;
    logic         in_inv = 1'b0;
    logic [127:0] out_data [4];

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int           id;
        logic [127:0] data;
        int           acc;
    } exp_t;
    exp_t q[$];

    int lat [4] = '{4, 16, 1, 4};

    logic [7:0] sb [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};
    logic [7:0] isb [256];

    sub_bytes_seq #(.LANES(4), .INV_EN(1)) u_l4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data),
        .in_inv(in_inv), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .busy(busy[0]));
    sub_bytes_seq #(.LANES(1), .INV_EN(1)) u_l1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data),
        .in_inv(in_inv), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .busy(busy[1]));
    sub_bytes_seq #(.LANES(16), .INV_EN(1)) u_l16 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data),
        .in_inv(in_inv), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
        .busy(busy[2]));
    sub_bytes_seq #(.LANES(4), .INV_EN(0)) u_fwd (
        .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]), .in_data(in_data),
        .in_inv(in_inv), .out_valid(out_valid[3]), .out_ready(out_ready[3]), .out_data(out_data[3]),
        .busy(busy[3]));

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [127:0] ref_sub(input logic [127:0] d, input bit inv);
        logic [127:0] r;
        r = d;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = inv ? isb[d[8*i +: 8]] : sb[d[8*i +: 8]];
        return r;
    endfunction

    // Offer one block to DUT `id`; on accept optionally push the expected result.
    task automatic send(input int id, input logic [127:0] data, input logic inv,
                        input bit push, input logic [127:0] expv);
        int n;
        n = 0;
        @(posedge clk); #1;
        in_data      = data;
        in_inv       = inv;
        in_valid[id] = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready[id] && n < 300);
        if (n >= 300) chk("accept_timeout", 128'(n), 128'(0));
        @(posedge clk); #1;
        in_valid[id] = 1'b0;
        if (push) q.push_back('{id: id, data: expv, acc: cyc});
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, 128'(q.size()), 128'(0));
    endtask

    // Monitor: latency on first out_valid, stability while stalled, data on handshake.
    exp_t         mon_e;
    logic [3:0]   prev_v = '0;
    logic [3:0]   hold = '0;
    logic [127:0] hold_d [4];

    always @(negedge clk) begin
        if (rst) begin
            prev_v <= '0;
            hold   <= '0;
        end else begin
            for (int d = 0; d < 4; d++) begin
                if (hold[d]) begin
                    chk("hold_valid", 128'(out_valid[d]), 128'(1));
                    chk("hold_data", out_data[d], hold_d[d]);
                end
                if (out_valid[d] && !prev_v[d]) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out: dut %0d out_valid=1 with nothing outstanding", d);
                    end else begin
                        chk("latency", 128'(cyc - q[0].acc), 128'(lat[d]));
                    end
                end
                if (out_valid[d] && out_ready[d] && q.size() != 0) begin
                    mon_e = q.pop_front();
                    chk("dut_id", 128'(d), 128'(mon_e.id));
                    chk("out_data", out_data[d], mon_e.data);
                end
                hold[d]   <= out_valid[d] && !out_ready[d];
                hold_d[d] <= out_data[d];
                prev_v[d] <= out_valid[d];
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] rd;
        bit           ri;
        bit           rnd_done;

        for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);

        // Reset state
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 4'b1111;
        @(negedge clk);
        chk("post_rst_in_ready", 128'(in_ready), 128'hf);
        chk("post_rst_out_data", out_data[0], 128'h0);

        // Known-answer vectors
        send(0, 128'h00112233445566778899aabbccddeeff, 1'b0, 1'b1, 128'h638293c31bfc33f5c4eeacea4bc12816);
        drain("t1_drain");
        send(0, 128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1, 1'b1, 128'h00112233445566778899aabbccddeeff);
        drain("t2_drain");

        // Output stall: data held, in_ready low, in_valid ignored
        out_ready[0] = 1'b0;
        send(0, 128'h000102030405060708090a0b0c0d0e0f, 1'b0, 1'b1, 128'h637c777bf26b6fc53001672bfed7ab76);
        begin
            int n;
            n = 0;
            while (!out_valid[0] && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid[0] = 1'b1;
            in_data     = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk("stall_in_ready", 128'(in_ready[0]), 128'(0));
            chk("stall_busy", 128'(busy[0]), 128'(1));
        end
        @(posedge clk); #1;
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release_in_ready", 128'(in_ready[0]), 128'(1));
        chk("release_out_valid", 128'(out_valid[0]), 128'(0));
        drain("t3_drain");

        // Reset during the second SUB cycle drops the block
        send(0, 128'h0123456789abcdeffedcba9876543210, 1'b0, 1'b0, 128'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rst_in_ready", 128'(in_ready[0]), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_out_valid", 128'(out_valid[0]), 128'(0));
        end
        chk("abort_out_data", out_data[0], 128'h0);
        chk("abort_in_ready", 128'(in_ready[0]), 128'(1));
        send(0, 128'h0, 1'b0, 1'b1, {16{8'h63}});
        drain("t4_drain");

        // Lane-count extremes and forward-only build
        send(1, {16{8'hff}}, 1'b0, 1'b1, {16{8'h16}});
        drain("t5_l1_drain");
        send(2, {16{8'hff}}, 1'b0, 1'b1, {16{8'h16}});
        drain("t5_l16_drain");
        send(2, 128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1, 1'b1, 128'h00112233445566778899aabbccddeeff);
        drain("t5_l16_inv_drain");
        send(3, 128'h0, 1'b1, 1'b1, {16{8'h63}});
        drain("t6_drain");

        // Random back-to-back blocks with random output stalls
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    rd = {$urandom, $urandom, $urandom, $urandom};
                    ri = 1'($urandom_range(0, 1));
                    send(0, rd, ri, 1'b1, ref_sub(rd, ri));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready[0] = ($urandom_range(0, 3) != 0);
                end
                out_ready[0] = 1'b1;
            end
        join
        drain("random_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
